tlc_conflict_monitor: RTL and testbench
=======================================

# tlc_conflict_monitor

Safety stage directly downstream of the traffic light controller. It consumes the controller's per-approach light codes and checks every cycle for conflicting greens, invalid codes, illegal sequencing and short yellows. While the inputs are legal it passes them to the lamp drivers with one register of latency. On any violation it latches a fault, forces both approaches to flashing red, and holds there until reset or a qualified clear.

## Interface
- MIN_YELLOW, default 3: minimum consecutive yellow cycles required before a yellow→red transition.
- FLASH_HALF, default 8: cycles per half-period of fault flashing (red phase, then dark phase).
- STARTUP_LIMIT, default 8: maximum cycles after reset that dark (0) input codes are tolerated.
- clock, input, 1: rising-edge clock.
- reset, input, 1: synchronous, active-high.
- ns_in, input, 4: North-South code from the controller; 1=red, 2=green, 4=yellow, 0=dark.
- ew_in, input, 4: East-West code, same encoding as ns_in.
- clear, input, 1: fault clear request; single-cycle pulse; honoured only in FAULT.
- ns_lamp, output, 4: registered North-South lamp drive, same encoding.
- ew_lamp, output, 4: registered East-West lamp drive, same encoding.
- fault, output, 1: high while in FAULT.
- fault_code, output, 3: cause of the latched fault; 0=none, 1=conflict, 2=invalid code, 3=illegal transition, 4=short yellow, 5=startup timeout.

## Operation
- Reset values: ns_lamp=0, ew_lamp=0, fault=0, fault_code=0, state=STARTUP. All counters and the previous-code registers are cleared to 0. Reset asserted mid-fault or mid-flash takes effect on the next edge.
- STARTUP:
  - Input code 0 is legal on either approach.
  - Lamps follow the inputs.
  - A conflict or a code outside {0,1,2,4} is checked exactly as in RUN.
  - Move to RUN on the first cycle where both inputs are in {1,2,4}. The transition check from 0 to any valid code is skipped.
  - If that does not happen within STARTUP_LIMIT cycles, fault with code 5.
- RUN: the checks below are evaluated on the current inputs. If several fire in the same cycle, the lowest-numbered code wins.
  - Code 1, conflict: neither input equals red.
  - Code 2, invalid: an input is not in {1,2,4}. Dark is illegal in RUN.
  - Code 3, illegal transition: a per-approach change other than red→green, green→yellow or yellow→red. Holding the same code is legal.
  - Code 4, short yellow: yellow→red after fewer than MIN_YELLOW consecutive yellow cycles.
  - With no violation, lamps load the inputs and the previous-code registers update.
- FAULT:
  - On the detection edge: fault=1, fault_code latched, lamps loaded with red/red. The offending codes never reach the lamps.
  - Flashing: red/red for FLASH_HALF cycles, then 0/0 for FLASH_HALF cycles, repeating.
  - The checks are not re-evaluated and fault_code stays frozen.
- Clear:
  - In FAULT, clear=1 with ns_in==ew_in==red causes the following on that edge: go to RUN, fault=0, fault_code=0, lamps=red/red, previous-code registers=red, yellow counters=0.
  - A clear without both inputs at red is ignored.
  - clear in STARTUP or RUN has no effect.
- Yellow counter (one per approach, 4 bits):
  - Increments while the input is yellow and saturates at MIN_YELLOW.
  - Reloads to 1 on entry to yellow.
  - Cleared when the input is not yellow.

## Timing
- Lamp latency: one cycle. Inputs sampled at edge N appear on the lamps after edge N.
- Fault latency: a violation present before edge N gives fault=1 and lamps red/red after edge N.
- The short-yellow check uses the counter value before the edge on which red is first sampled. With MIN_YELLOW=3, exactly 3 yellow cycles is legal and 2 is a fault.
- Flash counter, log2(2·FLASH_HALF) bits:
  - Starts at 0 on the detection edge.
  - Red phase covers counts 0..FLASH_HALF-1; dark phase covers FLASH_HALF..2·FLASH_HALF-1.
  - Wraps to 0 after the last dark cycle.
- The startup counter stops once RUN is reached. Timeout fires on the edge where the count reaches STARTUP_LIMIT while still in STARTUP.

## Structure
- Shared package tlc_pkg holds:
  - the light code constants RED, GREEN, YELLOW and DARK;
  - the fault code constants FC_NONE through FC_STARTUP;
  - the monitor state encoding STARTUP, RUN and FAULT.
- Sub-module tlc_approach_checker, instantiated once per approach:
  - holds the previous-code register and the yellow counter;
  - outputs illegal_trans and short_yellow;
  - takes load and reinit controls from the top FSM.
- Conflict and invalid-code checks, the fault latch, the flash counter and the startup counter live in the top module.

## Test plan
- Nominal cycle:
  - Stimulus: reset for 2 cycles; inputs 0/0 for 1 cycle; then green/red ×15, yellow/red ×3, red/red ×3, red/green ×15, red/yellow ×3, red/red ×3, repeated twice.
  - Response: lamps equal the inputs delayed by 1 cycle; fault stays 0.
- Conflict:
  - Stimulus: in RUN, drive ns=green, ew=yellow for one cycle.
  - Response: next cycle fault=1, fault_code=1, lamps=1/1. Lamps never show 2/4.
- Sequencing:
  - Stimulus: green→red on ns; separately, on a fresh run, yellow/red for only 2 cycles then red.
  - Response: fault_code=3 and fault_code=4 respectively.
- Flash and clear:
  - Stimulus: after a fault, observe 40 cycles; pulse clear while ns_in=green; later pulse clear with both inputs red.
  - Response: lamps show 1/1 ×8, 0/0 ×8, and repeat; the first clear is ignored; the second gives fault=0, fault_code=0, state RUN.
- Startup:
  - Stimulus: hold inputs at 0/0 after reset.
  - Response: fault_code=5 on the 8th cycle.
  - Stimulus: assert reset in the middle of a flash.
  - Response: all outputs 0 on the next cycle.
- Priority and invalid code:
  - Stimulus: drive ns=3, ew=green.
  - Response: fault_code=1, since conflict outranks invalid.
  - Stimulus: drive ns=0, ew=red while in RUN.
  - Response: fault_code=2.

Source files
------------

// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light conflict monitor.
//   - Light codes as driven by the controller and onto the lamp drivers.
//   - Fault cause codes reported on fault_code.
//   - Monitor state encoding.
package tlc_pkg;

  localparam logic [3:0] DARK   = 4'd0;
  localparam logic [3:0] RED    = 4'd1;
  localparam logic [3:0] GREEN  = 4'd2;
  localparam logic [3:0] YELLOW = 4'd4;

  typedef enum logic [2:0] {
    FC_NONE         = 3'd0,
    FC_CONFLICT     = 3'd1,
    FC_INVALID      = 3'd2,
    FC_TRANSITION   = 3'd3,
    FC_SHORT_YELLOW = 3'd4,
    FC_STARTUP      = 3'd5
  } fault_code_e;

  typedef enum logic [1:0] {
    STARTUP = 2'd0,
    RUN     = 2'd1,
    FAULT   = 2'd2
  } state_e;

  // True for the three codes a running controller may legally drive.
  function automatic logic is_valid(input logic [3:0] code);
    return (code == RED) || (code == GREEN) || (code == YELLOW);
  endfunction

endpackage

// File: rtl/tlc_conflict_monitor_if.sv
// Bus between the traffic light controller, the conflict monitor and the
// lamp drivers.
//   ns_in/ew_in  : per-approach light codes from the controller
//   clear        : single-cycle fault clear request
//   ns_lamp/ew_lamp : registered lamp drive
//   fault, fault_code : latched fault indication and cause
// master = controller/driver side, slave = monitor side.
interface tlc_conflict_monitor_if;

  logic [3:0] ns_in;
  logic [3:0] ew_in;
  logic       clear;
  logic [3:0] ns_lamp;
  logic [3:0] ew_lamp;
  logic       fault;
  logic [2:0] fault_code;

  modport master (
    output ns_in, ew_in, clear,
    input  ns_lamp, ew_lamp, fault, fault_code
  );

  modport slave (
    input  ns_in, ew_in, clear,
    output ns_lamp, ew_lamp, fault, fault_code
  );

endinterface

// File: rtl/tlc_approach_checker.sv
// Per-approach sequencing checker.
//   clock, reset  : clock, synchronous active-high reset
//   code_in       : current light code for this approach
//   load          : accept code_in as the new previous code (legal cycle)
//   reinit        : restart sequencing from red (fault clear)
//   illegal_trans : code_in is not a legal successor of the previous code
//   short_yellow  : yellow->red before MIN_YELLOW consecutive yellow cycles
module tlc_approach_checker
  import tlc_pkg::*;
#(
  parameter int MIN_YELLOW = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] code_in,
  input  logic       load,
  input  logic       reinit,
  output logic       illegal_trans,
  output logic       short_yellow
);

  localparam logic [3:0] YMAX = 4'(MIN_YELLOW);

  logic [3:0] prev_q, prev_d;
  logic [3:0] ycnt_q, ycnt_d;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and a latch cannot be inferred.
    prev_d = prev_q;
    ycnt_d = ycnt_q;
    if (reinit) begin
      prev_d = RED;
      ycnt_d = '0;
    end else if (load) begin
      prev_d = code_in;
      if (code_in == YELLOW) begin
        if (prev_q != YELLOW)   ycnt_d = 4'd1;
        else if (ycnt_q < YMAX) ycnt_d = ycnt_q + 4'd1;
      end else begin
        ycnt_d = '0;
      end
    end
  end

  always_comb begin
    illegal_trans = 1'b0;
    // A dark previous code only exists before the first legal load, where
    // any transition into a valid code is accepted.
    if (prev_q != DARK && code_in != prev_q) begin
      illegal_trans = !((prev_q == RED    && code_in == GREEN)  ||
                        (prev_q == GREEN  && code_in == YELLOW) ||
                        (prev_q == YELLOW && code_in == RED));
    end
    // Uses the count before the edge on which red is first sampled.
    short_yellow = (prev_q == YELLOW) && (code_in == RED) && (ycnt_q < YMAX);
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_q <= '0;
      ycnt_q <= '0;
    end else begin
      prev_q <= prev_d;
      ycnt_q <= ycnt_d;
    end
  end

endmodule

// File: rtl/tlc_conflict_monitor.sv
// Safety stage between the traffic light controller and the lamp drivers.
// Passes legal codes through with one register of latency; on a conflict,
// invalid code, illegal sequence, short yellow or startup timeout it latches
// the cause, forces flashing red and waits for reset or a clear with both
// inputs red.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : ns_in/ew_in/clear in, ns_lamp/ew_lamp/fault/fault_code out
module tlc_conflict_monitor
  import tlc_pkg::*;
#(
  parameter int MIN_YELLOW    = 3,
  parameter int FLASH_HALF    = 8,
  parameter int STARTUP_LIMIT = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  tlc_conflict_monitor_if.slave  bus
);

  localparam int FLASH_W = (FLASH_HALF > 1) ? $clog2(2 * FLASH_HALF) : 1;
  localparam int START_W = $clog2(STARTUP_LIMIT + 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(2 * FLASH_HALF - 1);
  localparam logic [FLASH_W-1:0] FLASH_DARK = FLASH_W'(FLASH_HALF);
  localparam logic [START_W-1:0] START_END  = START_W'(STARTUP_LIMIT);

  state_e              state_q, state_d;
  logic [3:0]          ns_lamp_q, ns_lamp_d;
  logic [3:0]          ew_lamp_q, ew_lamp_d;
  fault_code_e         fcode_q, fcode_d;
  logic [FLASH_W-1:0]  flash_q, flash_d;
  logic [START_W-1:0]  start_q, start_d;

  logic        load, reinit;
  logic        ns_trans, ns_short, ew_trans, ew_short;
  logic        fault_req;
  fault_code_e fault_cause;

  logic [3:0] ns, ew;
  logic       conflict_run, conflict_startup;
  logic       invalid_run, invalid_startup;

  assign ns = bus.ns_in;
  assign ew = bus.ew_in;

  // Neither approach showing red is a conflict. During startup a dark
  // approach is not yet driving anything, so it cannot conflict.
  assign conflict_run     = (ns != RED) && (ew != RED);
  assign conflict_startup = conflict_run && (ns != DARK) && (ew != DARK);
  assign invalid_run      = !is_valid(ns) || !is_valid(ew);
  assign invalid_startup  = (ns != DARK && !is_valid(ns)) ||
                            (ew != DARK && !is_valid(ew));

  tlc_approach_checker #(.MIN_YELLOW(MIN_YELLOW)) u_ns_checker (
    .clock        (clock),
    .reset        (reset),
    .code_in      (ns),
    .load         (load),
    .reinit       (reinit),
    .illegal_trans(ns_trans),
    .short_yellow (ns_short)
  );

  tlc_approach_checker #(.MIN_YELLOW(MIN_YELLOW)) u_ew_checker (
    .clock        (clock),
    .reset        (reset),
    .code_in      (ew),
    .load         (load),
    .reinit       (reinit),
    .illegal_trans(ew_trans),
    .short_yellow (ew_short)
  );

  always_comb begin
    state_d     = state_q;
    ns_lamp_d   = ns_lamp_q;
    ew_lamp_d   = ew_lamp_q;
    fcode_d     = fcode_q;
    flash_d     = flash_q;
    start_d     = start_q;
    load        = 1'b0;
    reinit      = 1'b0;
    fault_req   = 1'b0;
    fault_cause = FC_NONE;

    case (state_q)
      STARTUP: begin
        if (conflict_startup) begin
          fault_req   = 1'b1;
          fault_cause = FC_CONFLICT;
        end else if (invalid_startup) begin
          fault_req   = 1'b1;
          fault_cause = FC_INVALID;
        end else if (is_valid(ns) && is_valid(ew)) begin
          // Entry into RUN; the transition from dark is not checked.
          state_d   = RUN;
          ns_lamp_d = ns;
          ew_lamp_d = ew;
          load      = 1'b1;
        end else if (start_q + START_W'(1) == START_END) begin
          fault_req   = 1'b1;
          fault_cause = FC_STARTUP;
        end else begin
          start_d   = start_q + START_W'(1);
          ns_lamp_d = ns;
          ew_lamp_d = ew;
          load      = 1'b1;
        end
      end

      RUN: begin
        if (conflict_run) begin
          fault_req   = 1'b1;
          fault_cause = FC_CONFLICT;
        end else if (invalid_run) begin
          fault_req   = 1'b1;
          fault_cause = FC_INVALID;
        end else if (ns_trans || ew_trans) begin
          fault_req   = 1'b1;
          fault_cause = FC_TRANSITION;
        end else if (ns_short || ew_short) begin
          fault_req   = 1'b1;
          fault_cause = FC_SHORT_YELLOW;
        end else begin
          ns_lamp_d = ns;
          ew_lamp_d = ew;
          load      = 1'b1;
        end
      end

      FAULT: begin
        if (bus.clear && ns == RED && ew == RED) begin
          state_d   = RUN;
          fcode_d   = FC_NONE;
          ns_lamp_d = RED;
          ew_lamp_d = RED;
          flash_d   = '0;
          reinit    = 1'b1;
        end else begin
          flash_d   = (flash_q == FLASH_LAST) ? '0 : flash_q + FLASH_W'(1);
          ns_lamp_d = (flash_d < FLASH_DARK) ? RED : DARK;
          ew_lamp_d = (flash_d < FLASH_DARK) ? RED : DARK;
        end
      end

      default: state_d = STARTUP;
    endcase

    // Detection edge: offending codes never reach the lamps.
    if (fault_req) begin
      state_d   = FAULT;
      fcode_d   = fault_cause;
      ns_lamp_d = RED;
      ew_lamp_d = RED;
      flash_d   = '0;
    end
  end

  // NOTE: synchronous reset clears only control and datapath flops here;
  // there is no memory array that would need a reset decision.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= STARTUP;
      ns_lamp_q <= DARK;
      ew_lamp_q <= DARK;
      fcode_q   <= FC_NONE;
      flash_q   <= '0;
      start_q   <= '0;
    end else begin
      state_q   <= state_d;
      ns_lamp_q <= ns_lamp_d;
      ew_lamp_q <= ew_lamp_d;
      fcode_q   <= fcode_d;
      flash_q   <= flash_d;
      start_q   <= start_d;
    end
  end

  assign bus.ns_lamp    = ns_lamp_q;
  assign bus.ew_lamp    = ew_lamp_q;
  assign bus.fault      = (state_q == FAULT);
  assign bus.fault_code = fcode_q;

endmodule

// File: tb/tb_tlc_conflict_monitor.sv
// Directed testbench for tlc_conflict_monitor with default parameters
// (MIN_YELLOW=3, FLASH_HALF=8, STARTUP_LIMIT=8). Each observation packs
// {ns_lamp, ew_lamp, fault, fault_code} and compares it with a hand-derived
// expectation.
module tb_tlc_conflict_monitor;
  import tlc_pkg::*;

  logic clock = 1'b0;
  logic reset;

  always #5 clock = ~clock;

  tlc_conflict_monitor_if bus ();

  tlc_conflict_monitor dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [11:0] got,
                       input logic [11:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got ns=%0d ew=%0d fault=%0d code=%0d, expected ns=%0d ew=%0d fault=%0d code=%0d",
               tag, got[11:8], got[7:4], got[3], got[2:0],
               exp[11:8], exp[7:4], exp[3], exp[2:0]);
    end
  endtask

  function automatic logic [11:0] pack(input logic [3:0] ns_l,
                                       input logic [3:0] ew_l,
                                       input logic f, input logic [2:0] c);
    return {ns_l, ew_l, f, c};
  endfunction

  function automatic logic [11:0] obs();
    return {bus.ns_lamp, bus.ew_lamp, bus.fault, bus.fault_code};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are read there.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [3:0] ns_v, input logic [3:0] ew_v,
                       input logic clr);
    bus.ns_in = ns_v;
    bus.ew_in = ew_v;
    bus.clear = clr;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(DARK, DARK, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    check("reset", obs(), pack(DARK, DARK, 1'b0, 3'd0));
  endtask

  // Legal segment: lamps follow inputs one cycle later, no fault.
  task automatic seg(input logic [3:0] ns_v, input logic [3:0] ew_v,
                     input int n);
    for (int i = 0; i < n; i++) begin
      drive(ns_v, ew_v, 1'b0);
      tick();
      check("nominal", obs(), pack(ns_v, ew_v, 1'b0, 3'd0));
    end
  endtask

  initial begin
    logic [3:0] lamp;

    // Nominal cycle, including exactly 3 yellow cycles before red.
    do_reset();
    drive(DARK, DARK, 1'b0);
    tick();
    check("startup_dark", obs(), pack(DARK, DARK, 1'b0, 3'd0));
    repeat (2) begin
      seg(GREEN, RED, 15);
      seg(YELLOW, RED, 3);
      seg(RED, RED, 3);
      seg(RED, GREEN, 15);
      seg(RED, YELLOW, 3);
      seg(RED, RED, 3);
    end

    // Conflict green/yellow: red/red lamps, code 1 on the detection edge.
    drive(GREEN, YELLOW, 1'b0);
    tick();
    check("conflict", obs(), pack(RED, RED, 1'b1, 3'd1));

    // Flashing: count k since detection, red for k%16 < 8, dark otherwise.
    for (int k = 1; k < 40; k++) begin
      tick();
      lamp = ((k % 16) < 8) ? RED : DARK;
      check("flash", obs(), pack(lamp, lamp, 1'b1, 3'd1));
    end

    // k=40: clear with ns green is ignored, flashing continues (dark).
    drive(GREEN, RED, 1'b1);
    tick();
    check("clear_ignored", obs(), pack(DARK, DARK, 1'b1, 3'd1));
    drive(RED, RED, 1'b0);
    tick();
    check("flash_k41", obs(), pack(DARK, DARK, 1'b1, 3'd1));

    // Qualified clear back to RUN.
    drive(RED, RED, 1'b1);
    tick();
    check("clear", obs(), pack(RED, RED, 1'b0, 3'd0));
    drive(RED, GREEN, 1'b0);
    tick();
    check("run_after_clear", obs(), pack(RED, GREEN, 1'b0, 3'd0));
    drive(RED, GREEN, 1'b1);
    tick();
    check("clear_in_run", obs(), pack(RED, GREEN, 1'b0, 3'd0));

    // Illegal transition green->red.
    do_reset();
    drive(GREEN, RED, 1'b0);
    tick();
    check("enter_run", obs(), pack(GREEN, RED, 1'b0, 3'd0));
    drive(RED, RED, 1'b0);
    tick();
    check("illegal_trans", obs(), pack(RED, RED, 1'b1, 3'd3));

    // Short yellow: 2 yellow cycles then red.
    do_reset();
    seg(GREEN, RED, 1);
    seg(YELLOW, RED, 2);
    drive(RED, RED, 1'b0);
    tick();
    check("short_yellow", obs(), pack(RED, RED, 1'b1, 3'd4));

    // Startup timeout on the 8th cycle of dark inputs.
    do_reset();
    for (int i = 1; i < 8; i++) begin
      drive(DARK, DARK, 1'b0);
      tick();
      check("startup_wait", obs(), pack(DARK, DARK, 1'b0, 3'd0));
    end
    tick();
    check("startup_timeout", obs(), pack(RED, RED, 1'b1, 3'd5));

    // Reset in the dark half of a flash.
    repeat (10) tick();
    check("flash_dark", obs(), pack(DARK, DARK, 1'b1, 3'd5));
    reset = 1'b1;
    drive(RED, RED, 1'b0);
    tick();
    check("reset_mid_flash", obs(), pack(DARK, DARK, 1'b0, 3'd0));
    reset = 1'b0;

    // Conflict outranks invalid code.
    do_reset();
    seg(GREEN, RED, 1);
    drive(4'd3, GREEN, 1'b0);
    tick();
    check("priority_conflict", obs(), pack(RED, RED, 1'b1, 3'd1));

    // Dark in RUN is invalid (outranks the green->dark transition).
    do_reset();
    seg(GREEN, RED, 1);
    drive(DARK, RED, 1'b0);
    tick();
    check("invalid_dark", obs(), pack(RED, RED, 1'b1, 3'd2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
